pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline control unit for the RV32I core. It replaces the single global halt OR
//  (wfi | ~imem_rdy | ~dmem_rdy) with per-stage advance/flush/valid control for an N-stage pipeline.
//  It adds a load-use interlock, branch flush, WFI sleep, an interrupt drain/entry sequence and a
//  memory-stall watchdog. It sits beside the stage modules in cpu and drives their enables.
// PARAMETERS
//  NUM_STAGES   5    pipeline depth, legal 3..8; stage k maps to vector bit k-1
//  BR_STAGE     3    stage resolving branches, legal 2..NUM_STAGES-1
//  ID_STAGE     2    decode stage whose rs1/rs2 are checked for load-use, legal 1..BR_STAGE-1
//  MEM_TIMEOUT  255  consecutive memory-stall cycles before timeout_o sets; counter $clog2(MEM_TIMEOUT+1) bits
// PORTS
//  clk          input   1           rising-edge clock
//  reset        input   1           asynchronous, active-low reset
//  imem_rdy     input   1           instruction memory ready
//  dmem_rdy     input   1           data memory ready
//  interrupt    input   1           level interrupt request
//  wfi_dec      input   1           stage 1 holds a WFI
//  branch_taken input   1           taken branch/jump in BR_STAGE (qualified internally by valid)
//  ex_is_load   input   1           stage ID_STAGE+1 holds a load
//  ex_rd        input   5           rd of that load
//  id_rs1       input   5           rs1 of ID_STAGE instruction
//  id_rs2       input   5           rs2 of ID_STAGE instruction
//  stage_en     output  NUM_STAGES  stage k register captures this cycle
//  stage_valid  output  NUM_STAGES  stage k holds a live instruction
//  fetch_en     output  1           PC may advance
//  irq_take     output  1           one-cycle pulse: redirect PC to trap vector
//  wfi_o        output  1           core asleep in WFI
//  timeout_o    output  1           sticky memory watchdog error
//  perf_stall   output  32          memory-stall cycle count (see CONFIGURATION)
//  perf_flush   output  32          branch-flush count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=RUN, stage_valid=0, irq_pending=0, wd counter=0, timeout_o=0, perf=0. All outputs
//   are combinational from these, so stage_en=all-1, fetch_en=1, irq_take=0, wfi_o=0.
//  Priority each cycle: mem stall > branch flush > load-use > WFI/IRQ FSM.
//  Mem stall (~imem_rdy|~dmem_rdy): stage_en=0, fetch_en=0, valid held, FSM frozen.
//   Branch and load-use are re-evaluated next cycle because inputs are held.
//   Watchdog increments per stall cycle and clears on the first non-stall cycle.
//   On reaching MEM_TIMEOUT, timeout_o=1 until reset. Counter saturates and does not wrap.
//  Flush (branch_taken & valid[BR_STAGE]): valid[1..BR_STAGE-1] cleared at the edge.
//   Stages >=BR_STAGE advance normally. Any concurrent load-use is dropped. perf_flush++.
//  Load-use (ex_is_load & valid[ID_STAGE+1] & valid[ID_STAGE] & ex_rd!=0 & ex_rd in {rs1,rs2}):
//   stage_en[1..ID_STAGE]=0, fetch_en=0, bubble (valid=0) into ID_STAGE+1. Exactly one cycle.
//  Valid shift on advance: valid[k+1]<=valid[k]; valid[1]<=fetch_en; the last stage retires.
//  irq_pending sets on interrupt=1 and clears on irq_take.
//  FSM:
//   RUN: wfi_dec & valid[1] & no stall/flush -> SLEEP. If irq_pending, go to DRAIN instead.
//   SLEEP: wfi_o=1, fetch_en=0, older stages drain. irq_pending -> DRAIN.
//   DRAIN: fetch_en=0, bubbles into stage 1. When valid[2..NUM_STAGES]==0 -> ENTER.
//    A branch flush during DRAIN is still applied.
//   ENTER: irq_take=1 for 1 cycle, fetch_en=1, valid[1..NUM_STAGES] cleared -> RUN.
//  Latency: interrupt to irq_take = 1 + cycles to empty stages 2..N (N-1 when no stalls).
//  Reset mid-stall or mid-drain returns immediately to the reset state. No pending IRQ survives reset.
// CONFIGURATION
//  PIPE_HAZARD_CTRL_PERF_EN defined: perf_stall counts mem-stall cycles and perf_flush counts
//   flushes. Both are 32-bit, wrap modulo 2^32 and reset to 0.
//  Not defined: no counters are built and perf_stall/perf_flush are driven to constant 0.
// TESTING
//  1 reset low 3 cycles, release, rdy=1 -> stage_valid fills 00001..11111 over 5 cycles, stage_en=11111.
//  2 ex_is_load=1, ex_rd=5, id_rs2=5, valid[2],[3]=1 -> stage_en=11100 for 1 cycle,
//    valid[3]=0 next cycle. Repeat with ex_rd=0 -> no stall.
//  3 branch_taken with valid[3]=1 and a coincident load-use -> valid[1..2]=0 next cycle,
//    no load-use stall, perf_flush=1 (PERF_EN).
//  4 dmem_rdy=0 for 255 cycles -> stage_en=0 throughout, timeout_o=1 on cycle 255 and stays
//    after dmem_rdy=1. With 254 cycles, timeout_o stays 0.
//  5 wfi_dec in RUN -> wfi_o=1 and stages drain. interrupt pulse at t -> irq_take at t+5
//    (N=5, no stalls), then RUN with fetch_en=1.
//  6 dmem_rdy=0 during DRAIN -> drain frozen, irq_take delayed by the stall length. Reset asserted
//    mid-drain -> state RUN, irq_pending=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Per-stage advance/flush/valid control for the RV32I pipeline: memory-stall
//   freeze with watchdog, branch flush, load-use interlock and a WFI / interrupt
//   drain-and-enter sequencer.
//   Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN builds the 32-bit stall and
//   flush event counters; without it perf_stall/perf_flush are tied to zero.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES  = 5,
   parameter int BR_STAGE    = 3,
   parameter int ID_STAGE    = 2,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  imem_rdy,
   input  logic                  dmem_rdy,
   input  logic                  interrupt,
   input  logic                  wfi_dec,
   input  logic                  branch_taken,
   input  logic                  ex_is_load,
   input  logic [4:0]            ex_rd,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic                  fetch_en,
   output logic                  irq_take,
   output logic                  wfi_o,
   output logic                  timeout_o,
   output logic [31:0]           perf_stall,
   output logic [31:0]           perf_flush
);

   localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MEM_TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SLEEP = 2'd1,
      DRAIN = 2'd2,
      ENTER = 2'd3
   } state_t;

   state_t                state;
   logic [NUM_STAGES-1:0] valid_q;
   logic [NUM_STAGES-1:0] valid_nxt;
   logic                  irq_pending;
   logic [WD_W-1:0]       wd_cnt;
   logic                  timeout_q;

   logic                  mem_stall;
   logic                  flush;
   logic                  load_use;
   logic                  drained;

   // Hazard qualifiers, in priority order: memory stall masks everything,
   // a flush squashes the instruction that would otherwise interlock.
   assign mem_stall = ~imem_rdy | ~dmem_rdy;
   assign flush     = branch_taken & valid_q[BR_STAGE-1] & ~mem_stall;
   assign load_use  = ex_is_load & valid_q[ID_STAGE] & valid_q[ID_STAGE-1]
                    & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))
                    & ~mem_stall & ~flush & (state != ENTER);

   // The trap redirect fires only on a cycle where the pipeline actually moves,
   // so a stall during ENTER cannot stretch it into a multi-cycle pulse.
   assign irq_take    = (state == ENTER) & ~mem_stall;
   assign wfi_o       = (state == SLEEP);
   assign stage_valid = valid_q;
   assign timeout_o   = timeout_q;

   // PC advance: only RUN (outside an interlock) and the trap-entry cycle fetch.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      fetch_en = 1'b0;
      if (!mem_stall) begin
         case (state)
            RUN:     fetch_en = ~load_use;
            ENTER:   fetch_en = 1'b1;
            default: fetch_en = 1'b0;
         endcase
      end
   end

   // Stage register enables: all frozen on a memory stall, front end held on load-use.
   always_comb begin
      stage_en = '1;
      if (mem_stall) begin
         stage_en = '0;
      end else if (load_use) begin
         stage_en[ID_STAGE-1:0] = '0;
      end
   end

   // Next valid vector: shift toward retirement, then apply ENTER/flush/bubble.
   always_comb begin
      valid_nxt = {valid_q[NUM_STAGES-2:0], fetch_en};
      if (mem_stall) begin
         valid_nxt = valid_q;
      end else if (state == ENTER) begin
         valid_nxt = '0;
      end else if (flush) begin
         valid_nxt[BR_STAGE-2:0] = '0;
      end else if (load_use) begin
         valid_nxt[ID_STAGE-1:0] = valid_q[ID_STAGE-1:0];
         valid_nxt[ID_STAGE]     = 1'b0;
      end
   end

   // Stages 2..N will be empty after this edge: the drain is complete.
   assign drained = (valid_nxt[NUM_STAGES-1:1] == '0);

   // Sequencer state, valid vector and pending-interrupt latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         valid_q     <= '0;
         irq_pending <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         if (irq_take) begin
            irq_pending <= 1'b0;
         end else if (interrupt) begin
            irq_pending <= 1'b1;
         end

         if (!mem_stall) begin
            valid_q <= valid_nxt;
            case (state)
               RUN: begin
                  if (irq_pending) begin
                     state <= DRAIN;
                  end else if (wfi_dec & valid_q[0] & ~flush) begin
                     state <= SLEEP;
                  end
               end
               SLEEP: begin
                  if (irq_pending) begin
                     state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (drained) begin
                     state <= ENTER;
                  end
               end
               default: state <= RUN;
            endcase
         end
      end
   end

   // Memory watchdog: counts consecutive stall cycles, saturates, sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else if (mem_stall) begin
         if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (wd_cnt == WD_LAST) begin
            timeout_q <= 1'b1;
         end
      end else begin
         wd_cnt <= '0;
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (mem_stall) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (flush) begin
            perf_flush_q <= perf_flush_q + 32'd1;
         end
      end
   end

   assign perf_stall = perf_stall_q;
   assign perf_flush = perf_flush_q;
`else
   assign perf_stall = '0;
   assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl at the default geometry
//   (5 stages, branch in 3, decode in 2, watchdog 255).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       imem_rdy, dmem_rdy, interrupt, wfi_dec, branch_taken, ex_is_load;
   logic [4:0] ex_rd, id_rs1, id_rs2;
   logic [4:0] stage_en, stage_valid;
   logic       fetch_en, irq_take, wfi_o, timeout_o;
   logic [31:0] perf_stall, perf_flush;

   int n_run  = 0;
   int n_fail = 0;
   int lat;
   logic flag;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .imem_rdy     (imem_rdy),
      .dmem_rdy     (dmem_rdy),
      .interrupt    (interrupt),
      .wfi_dec      (wfi_dec),
      .branch_taken (branch_taken),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .stage_en     (stage_en),
      .stage_valid  (stage_valid),
      .fetch_en     (fetch_en),
      .irq_take     (irq_take),
      .wfi_o        (wfi_o),
      .timeout_o    (timeout_o),
      .perf_stall   (perf_stall),
      .perf_flush   (perf_flush)
   );

   // Advance to 2 ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_run++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clear_inputs();
      interrupt    = 1'b0;
      wfi_dec      = 1'b0;
      branch_taken = 1'b0;
      ex_is_load   = 1'b0;
      ex_rd        = 5'd0;
      id_rs1       = 5'd0;
      id_rs2       = 5'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL tb_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      clear_inputs();
      imem_rdy = 1'b1;
      dmem_rdy = 1'b1;

      // ---- reset state ----
      repeat (3) cyc();
      #1;
      check("rst_valid",  stage_valid, 5'b00000);
      check("rst_en",     stage_en,    5'b11111);
      check("rst_fetch",  fetch_en,    1'b1);
      check("rst_take",   irq_take,    1'b0);
      check("rst_wfi",    wfi_o,       1'b0);
      check("rst_tmo",    timeout_o,   1'b0);
      check("rst_pstall", perf_stall,  32'd0);
      check("rst_pflush", perf_flush,  32'd0);
      reset = 1'b1;

      // ---- pipeline fill ----
      for (int k = 1; k <= 5; k++) begin
         cyc();
         #1;
         check("fill_valid", stage_valid, (32'd1 << k) - 32'd1);
         check("fill_en",    stage_en,    5'b11111);
      end

      // ---- load-use interlock ----
      ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd0; id_rs2 = 5'd5;
      #1;
      check("lu_en",    stage_en, 5'b11100);
      check("lu_fetch", fetch_en, 1'b0);
      cyc(); #1;
      check("lu_bubble", stage_valid, 5'b11011);
      check("lu_once",   stage_en,    5'b11111);
      cyc();
      ex_rd = 5'd0; id_rs2 = 5'd0;
      #1;
      check("lu_x0", stage_en, 5'b11111);
      ex_rd = 5'd5; id_rs1 = 5'd6; id_rs2 = 5'd7;
      #1;
      check("lu_nomatch", stage_en, 5'b11111);
      ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd0;
      #1;
      check("lu_rs1", stage_en, 5'b11100);
      cyc(); #1;
      check("lu_rs1_bubble", stage_valid, 5'b01011);
      clear_inputs();
      repeat (5) cyc();
      #1;
      check("refill_1", stage_valid, 5'b11111);

      // ---- branch flush beats a coincident load-use ----
      branch_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
      #1;
      check("br_en",    stage_en, 5'b11111);
      check("br_fetch", fetch_en, 1'b1);
      cyc();
      clear_inputs();
      #1;
      check("br_valid", stage_valid, 5'b11100);
      check("br_perf",  perf_flush,  PERF);
      cyc();
      branch_taken = 1'b1;
      #1;
      check("br_inv_en", stage_en, 5'b11111);
      cyc();
      branch_taken = 1'b0;
      #1;
      check("br_inval",      stage_valid, 5'b10011);
      check("br_inval_perf", perf_flush,  PERF);

      // ---- instruction-memory stall holds a partial valid pattern ----
      imem_rdy = 1'b0;
      #1;
      check("im_en",    stage_en, 5'b00000);
      check("im_fetch", fetch_en, 1'b0);
      cyc();
      imem_rdy = 1'b1;
      #1;
      check("im_hold", stage_valid, 5'b10011);
      repeat (5) cyc();
      #1;
      check("refill_2", stage_valid, 5'b11111);

      // ---- watchdog: 254 stall cycles, no timeout; stall beats a flush ----
      dmem_rdy = 1'b0; branch_taken = 1'b1;
      #1;
      check("wd_en", stage_en, 5'b00000);
      cyc();
      branch_taken = 1'b0;
      #1;
      check("wd_br_held", stage_valid, 5'b11111);
      flag = 1'b0;
      for (int i = 1; i < 254; i++) begin
         cyc();
         if (stage_en !== 5'b00000 || fetch_en !== 1'b0) flag = 1'b1;
      end
      #1;
      check("wd_en_all", flag,      1'b0);
      check("wd_254",    timeout_o, 1'b0);
      dmem_rdy = 1'b1;
      cyc(); #1;
      check("wd_254_after", timeout_o,  1'b0);
      check("wd_pstall_1",  perf_stall, PERF * 255);

      // ---- watchdog: 255 stall cycles trips and sticks ----
      dmem_rdy = 1'b0;
      repeat (254) cyc();
      #1;
      check("wd_pre", timeout_o, 1'b0);
      cyc(); #1;
      check("wd_255", timeout_o, 1'b1);
      dmem_rdy = 1'b1;
      repeat (3) cyc();
      #1;
      check("wd_sticky",   timeout_o,  1'b1);
      check("wd_pstall_2", perf_stall, PERF * 510);
      check("wd_valid",    stage_valid, 5'b11111);

      // ---- WFI sleep, then interrupt drain/entry ----
      wfi_dec = 1'b1;
      #1;
      check("wfi_run", wfi_o, 1'b0);
      cyc();
      wfi_dec = 1'b0;
      #1;
      check("wfi_sleep", wfi_o,    1'b1);
      check("wfi_fetch", fetch_en, 1'b0);
      interrupt = 1'b1;
      #1;
      check("irq_t", irq_take, 1'b0);
      cyc();
      interrupt = 1'b0;
      lat = 1;
      while (!irq_take && lat < 20) begin
         cyc();
         lat++;
      end
      check("irq_lat", lat, 5);
      #1;
      check("ent_fetch", fetch_en,    1'b1);
      check("ent_valid", stage_valid, 5'b00000);
      cyc(); #1;
      check("irq_pulse", irq_take, 1'b0);
      check("run_fetch", fetch_en, 1'b1);
      check("run_wfi",   wfi_o,    1'b0);

      // ---- data stall during DRAIN stretches the latency ----
      repeat (6) cyc();
      wfi_dec = 1'b1;
      cyc();
      wfi_dec = 1'b0; interrupt = 1'b1;
      cyc();
      interrupt = 1'b0;
      cyc();
      dmem_rdy = 1'b0;
      lat = 2;
      repeat (3) begin
         cyc();
         lat++;
      end
      #1;
      check("dr_hold",   stage_valid, 5'b11100);
      check("dr_notake", irq_take,    1'b0);
      dmem_rdy = 1'b1;
      while (!irq_take && lat < 30) begin
         cyc();
         lat++;
      end
      check("dr_lat", lat, 8);

      // ---- reset in the middle of a drain ----
      cyc();
      repeat (6) cyc();
      wfi_dec = 1'b1;
      cyc();
      wfi_dec = 1'b0; interrupt = 1'b1;
      cyc();
      interrupt = 1'b0;
      cyc();
      #1;
      check("mid_drain_fetch", fetch_en, 1'b0);
      reset = 1'b0;
      #1;
      check("mr_valid", stage_valid, 5'b00000);
      check("mr_fetch", fetch_en,    1'b1);
      check("mr_tmo",   timeout_o,   1'b0);
      check("mr_pstall", perf_stall, 32'd0);
      cyc();
      reset = 1'b1;
      flag = 1'b0;
      repeat (10) begin
         cyc();
         if (irq_take !== 1'b0 || wfi_o !== 1'b0) flag = 1'b1;
      end
      check("mr_no_irq", flag,        1'b0);
      check("mr_refill", stage_valid, 5'b11111);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
